// File: rtl/myproject_dense_pkg.sv
// Shared types and width constants for the dense-layer accumulator slice.
package myproject_dense_pkg;

  localparam int unsigned PROD_W    = 22;
  localparam int unsigned BIAS_W    = 16;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned OUT_SHIFT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Accumulator width: product width plus enough guard bits for n_in terms plus bias.
  function automatic int unsigned acc_w_f(input int unsigned prod_w, input int unsigned n_in);
    return prod_w + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/myproject_dense_narrow.sv
// Combinational narrowing of the accumulator to the layer output width.
// Arithmetic shift right by OUT_SHIFT (truncation toward -inf), then either
// two's-complement wrap (default) or saturation when MYPROJECT_DENSE_ACC_SAT_EN
// is defined.
module myproject_dense_narrow
  import myproject_dense_pkg::*;
#(
  parameter int unsigned ACC_W = 27
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [OUT_W-1:0] data_o
);

`ifdef MYPROJECT_DENSE_ACC_SAT_EN
  logic signed [ACC_W-1:0]     t;
  logic        [ACC_W-OUT_W:0] hi;

  // Saturate when the bits above the output sign bit are not all sign copies.
  always_comb begin
    t  = acc_i >>> OUT_SHIFT;
    hi = t[ACC_W-1:OUT_W-1];
    if ((&hi) || (~|hi)) begin
      data_o = t[OUT_W-1:0];
    end else if (t[ACC_W-1]) begin
      data_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      data_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  // Wrap: keep the low OUT_W bits of the shifted value.
  always_comb begin
    data_o = OUT_W'(acc_i >>> OUT_SHIFT);
  end
`endif

endmodule

// File: rtl/myproject_dense_acc.sv
// Dense-layer accumulator: sums N_IN signed products plus a per-neuron bias,
// narrows the result and hands it downstream over valid/ready.
// Narrowing mode is selected in myproject_dense_narrow by MYPROJECT_DENSE_ACC_SAT_EN.
module myproject_dense_acc
  import myproject_dense_pkg::*;
#(
  parameter int unsigned N_IN = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic signed [BIAS_W-1:0] in_bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [OUT_W-1:0]  out_data
);

  localparam int unsigned CNT_W = $clog2(N_IN);
  localparam int unsigned ACC_W = acc_w_f(PROD_W, N_IN);

  state_e                  state_q, state_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic        [OUT_W-1:0] out_data_q, out_data_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_sum;
  logic        [OUT_W-1:0] narrow_data;

  // Sign-extend operands; the first beat of a neuron starts from the bias instead of acc.
  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    bias_ext = {{(ACC_W-BIAS_W){in_bias[BIAS_W-1]}}, in_bias};
    acc_base = (state_q == IDLE) ? bias_ext : acc_q;
    acc_sum  = acc_base + prod_ext;
  end

  myproject_dense_narrow #(
    .ACC_W(ACC_W)
  ) u_narrow (
    .acc_i (acc_sum),
    .data_o(narrow_data)
  );

  // Next-state and datapath update; in_ready depends on registered state only.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    in_ready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = acc_sum;
          cnt_d   = CNT_W'(1);
          state_d = ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_sum;
          if (cnt_q == CNT_W'(N_IN - 1)) begin
            out_data_d  = narrow_data;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that discards any partial sum or pending result.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
